sub_byte_engine: RTL and testbench
==================================

// Module: sub_byte_engine
// PURPOSE
//  Sequential, parametrised AES byte-substitution stage. Combines SubBytes and ShiftRows for encryption.
//  Combines InvSubBytes and InvShiftRows for decryption. Mode is selected per block.
//  Processes LANES S-box lookups per cycle, so one 128-bit state takes 16/LANES cycles.
//  Sits between the AddRoundKey and MixColumns stages. Uses a valid/ready handshake on both sides.
// PARAMETERS
//  LANES     4  S-box lookups per cycle; legal values 1,2,4,8,16; any other value is an elaboration $error
//  SHIFT_EN  1  1: apply (Inv)ShiftRows on output; 0: pure byte substitution, byte order unchanged
// PORTS
//  clk              in   1       rising-edge clock
//  n_rst            in   1       synchronous, active-low reset
//  in_valid         in   1       state_array_in and inverse are valid
//  in_ready         out  1       engine can accept a block (high only in IDLE)
//  inverse          in   1       0: forward S-box and ShiftRows; 1: inverse S-box and InvShiftRows
//  state_array_in   in   [0:15][7:0]  input state, byte k = row k%4, column k/4
//  out_valid        out  1       state_array_out holds a finished block
//  out_ready        in   1       downstream accepts the block
//  state_array_out  out  [0:15][7:0]  result, same byte ordering as the input
//  busy             out  1       high in SUB or DONE
// BEHAVIOUR
//  Reset:
//   - On a clk edge with n_rst=0: state to IDLE, cnt=0, work buffer to 0, mode register to 0.
//   - Output values in reset: in_ready=1, out_valid=0, busy=0, state_array_out=0.
//   - A reset during SUB or DONE aborts the block; no partial output is produced.
//  FSM states IDLE, SUB, DONE:
//   - IDLE: in_ready=1. When in_valid=1, latch state_array_in into buf and latch inverse into mode; go to SUB with cnt=0.
//   - SUB: each cycle replace buf[cnt*LANES+i], for i=0..LANES-1, with SBOX[byte] if mode=0, or INV_SBOX[byte] if mode=1. Then cnt++.
//   - SUB exit: on the cycle that processes cnt = 16/LANES-1, go to DONE and reset cnt to 0.
//   - DONE: out_valid=1. state_array_out is held stable until out_ready=1, then go to IDLE.
//   - DONE does not accept new input. There is no input/output overlap, so throughput is one block per (16/LANES + 2) cycles minimum.
//  Latency:
//   - Handshake accepted at edge T; out_valid rises after edge T + 16/LANES.
//   - Example: LANES=16 gives out_valid one cycle after acceptance.
//  Input stability:
//   - The inverse input and state_array_in are ignored outside IDLE.
//   - Changes to them mid-block have no effect.
//  Output mapping (combinational from buf; r = k%4, c = k/4):
//   - SHIFT_EN=0: out[k] = buf[k].
//   - Forward: out[4c+r] = buf[4*((c+r)%4)+r]. For example, out[1]=buf[5] and out[7]=buf[3].
//   - Inverse: out[4c+r] = buf[4*((c-r+4)%4)+r]. For example, out[1]=buf[13] and out[13]=buf[9].
//  Tables and width rules:
//   - SBOX and INV_SBOX are the FIPS-197 tables, 256x8 constant ROMs.
//   - The table index is the raw 8-bit byte; no arithmetic on nibbles.
//   - cnt is clog2(16/LANES) bits wide, minimum 1 bit.
//  Simultaneous events:
//   - n_rst=0 has priority over every handshake.
//   - out_ready has no effect outside DONE.
//   - in_valid has no effect outside IDLE.
// TESTING
//  1. Reset: hold n_rst=0 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, busy=0, state_array_out=0.
//  2. FIPS-197 App. B round 1, LANES=4, inverse=0:
//     - Stimulus: in = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08.
//     - Response: out_valid exactly 4 cycles after acceptance, out = d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5.
//  3. Inverse round-trip: feed the test 2 output with inverse=1 -> out = 19 3d e3 be ... 48 08. Repeat for LANES = 1, 2, 8, 16; latency must be 16, 8, 2, 1.
//  4. SHIFT_EN=0, all bytes 00 then all 53, forward -> all 63, then all ed. Inverse of all 63 -> all 00.
//  5. Backpressure: out_ready=0 for 10 cycles in DONE -> out stable, in_ready=0. Toggle inverse and the input during this time -> no change. out_ready=1 -> IDLE next cycle.
//  6. Reset mid-SUB (LANES=1, cycle 7) -> IDLE next edge, out_valid never asserts. The next block processes correctly.

Source files
------------

// File: rtl/sub_byte_engine.sv
// AES (Inv)SubBytes + optional (Inv)ShiftRows stage with LANES S-box lookups per cycle.
// A 16-byte state is taken in IDLE, substituted in place over 16/LANES cycles, then held in DONE.
`timescale 1ns/1ps
module sub_byte_engine #(
   parameter int LANES    = 4,
   parameter bit SHIFT_EN = 1'b1
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             inverse,
   input  logic [0:15][7:0] state_array_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:15][7:0] state_array_out,
   output logic             busy
);

   localparam int STEPS = (LANES > 0) ? 16 / LANES : 1;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
      $error("sub_byte_engine: LANES must be 1, 2, 4, 8 or 16 (got %0d)", LANES);
   end

   // Index 0 is the leftmost byte of each table.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [0:15][7:0] work_buf;
   logic             mode;

   function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
      return inv ? INV_SBOX[b] : SBOX[b];
   endfunction

   // Substitutes the LANES bytes of slice c, leaving every other byte untouched.
   function automatic logic [0:15][7:0] sub_lanes(input logic [0:15][7:0] s,
                                                  input logic [CNT_W-1:0] c,
                                                  input logic inv);
      logic [0:15][7:0] r;
      logic [3:0]       idx;
      r = s;
      for (int i = 0; i < LANES; i++) begin
         idx    = 4'((int'(c) * LANES) + i);
         r[idx] = sub_byte(s[idx], inv);
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         work_buf  <= '0;
         mode      <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work_buf <= state_array_in;
                  mode     <= inverse;
                  cnt      <= '0;
                  state    <= SUB;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            SUB: begin
               work_buf <= sub_lanes(work_buf, cnt, mode);
               if (cnt == CNT_LAST) begin
                  cnt       <= '0;
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Row r of the output is row r of the buffer rotated by r columns (left forward, right inverse).
   for (genvar k = 0; k < 16; k++) begin : g_map
      localparam int R       = k % 4;
      localparam int C       = k / 4;
      localparam int SRC_FWD = 4 * ((C + R) % 4) + R;
      localparam int SRC_INV = 4 * ((C - R + 4) % 4) + R;
      if (SHIFT_EN) begin : g_shift
         assign state_array_out[k] = mode ? work_buf[SRC_INV] : work_buf[SRC_FWD];
      end else begin : g_flat
         assign state_array_out[k] = work_buf[k];
      end
   end

endmodule

// File: tb/tb_sub_byte_engine.sv
// Bench for sub_byte_engine: six configurations checked every cycle against a timestamp/GF(2^8) model.
`timescale 1ns/1ps
module tb_sub_byte_engine;

   localparam int NI = 6;
   localparam int LANES_T [NI] = '{1, 2, 4, 8, 16, 4};
   localparam bit SHIFT_T [NI] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam int LAT_T   [NI] = '{16, 8, 4, 2, 1, 4};
   localparam logic [0:15][7:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [0:15][7:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

   logic clk = 1'b0;
   logic n_rst     [NI];
   logic in_valid  [NI];
   logic in_ready  [NI];
   logic inverse   [NI];
   logic out_valid [NI];
   logic out_ready [NI];
   logic busy      [NI];
   logic [0:15][7:0] din  [NI];
   logic [0:15][7:0] dout [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      sub_byte_engine #(.LANES(LANES_T[g]), .SHIFT_EN(SHIFT_T[g])) dut (
         .clk            (clk),
         .n_rst          (n_rst[g]),
         .in_valid       (in_valid[g]),
         .in_ready       (in_ready[g]),
         .inverse        (inverse[g]),
         .state_array_in (din[g]),
         .out_valid      (out_valid[g]),
         .out_ready      (out_ready[g]),
         .state_array_out(dout[g]),
         .busy           (busy[g])
      );
   end

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [7:0] fwd_tab [256];
   logic [7:0] inv_tab [256];

   bit               m_known  [NI];
   bit               m_active [NI];
   int               m_acc    [NI];
   logic [0:15][7:0] m_exp    [NI];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = (b << n) | (b >> (8 - n));
      return r;
   endfunction

   // Substitute every byte, then rotate row r by r columns (left forward, right inverse).
   function automatic logic [0:15][7:0] xform(input logic [0:15][7:0] d, input logic iv, input bit sh);
      logic [0:15][7:0] s, o;
      for (int k = 0; k < 16; k++) s[k] = iv ? inv_tab[d[k]] : fwd_tab[d[k]];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (!sh)     o[4*c+r] = s[4*c+r];
            else if (iv) o[4*c+r] = s[4*((c + 4 - r) % 4) + r];
            else         o[4*c+r] = s[4*((c + r) % 4) + r];
      return o;
   endfunction

   // Model: a block accepted at edge A is visible as out_valid from edge A+latency until taken.
   always @(posedge clk) begin
      cyc++;
      for (int j = 0; j < NI; j++) begin
         if (!n_rst[j]) begin
            m_known[j]  = 1'b1;
            m_active[j] = 1'b0;
            m_exp[j]    = '0;
         end else if (m_known[j]) begin
            if (!m_active[j]) begin
               if (in_valid[j]) begin
                  m_active[j] = 1'b1;
                  m_acc[j]    = cyc;
                  m_exp[j]    = xform(din[j], inverse[j], SHIFT_T[j]);
               end
            end else if ((cyc - 1 >= m_acc[j] + LAT_T[j]) && out_ready[j]) begin
               m_active[j] = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int j = 0; j < NI; j++) begin
         if (m_known[j]) begin
            logic ov;
            ov = m_active[j] && (cyc >= m_acc[j] + LAT_T[j]);
            chk($sformatf("inst%0d in_ready", j),  128'(in_ready[j]),  128'(!m_active[j]));
            chk($sformatf("inst%0d busy", j),      128'(busy[j]),      128'(m_active[j]));
            chk($sformatf("inst%0d out_valid", j), 128'(out_valid[j]), 128'(ov));
            if (!m_active[j] || ov)
               chk($sformatf("inst%0d data", j), dout[j], m_exp[j]);
         end
      end
   end

   task automatic run_block(input int j, input logic [0:15][7:0] d, input logic iv,
                            input logic [0:15][7:0] expv, input int exp_lat, input string nm);
      int lat;
      in_valid[j] = 1'b1;
      inverse[j]  = iv;
      din[j]      = d;
      @(posedge clk); #1;
      in_valid[j] = 1'b0;
      inverse[j]  = ~iv;
      din[j]      = ~d;
      lat = 0;
      while (out_valid[j] !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
      chk({nm, " data"}, dout[j], expv);
      out_ready[j] = 1'b1;
      @(posedge clk); #1;
      out_ready[j] = 1'b0;
      chk({nm, " in_ready after take"}, 128'(in_ready[j]), 128'(1'b1));
      chk({nm, " out_valid after take"}, 128'(out_valid[j]), 128'(1'b0));
   endtask

   initial begin
      for (int x = 0; x < 256; x++) begin
         logic [7:0] xi, b;
         xi = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
         b = xi;
         fwd_tab[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      end
      for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

      chk("model sbox[00]", 128'(fwd_tab[8'h00]), 128'h63);
      chk("model sbox[53]", 128'(fwd_tab[8'h53]), 128'hed);
      chk("model sbox[19]", 128'(fwd_tab[8'h19]), 128'hd4);
      chk("model inv_sbox[63]", 128'(inv_tab[8'h63]), 128'h00);
      chk("model fips fwd", xform(FIPS_IN, 1'b0, 1'b1), FIPS_OUT);
      chk("model fips inv", xform(FIPS_OUT, 1'b1, 1'b1), FIPS_IN);

      for (int j = 0; j < NI; j++) begin
         n_rst[j]     = 1'b0;
         in_valid[j]  = 1'b1;
         inverse[j]   = 1'b0;
         din[j]       = {$urandom(), $urandom(), $urandom(), $urandom()};
         out_ready[j] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int j = 0; j < NI; j++) begin
         chk($sformatf("reset inst%0d in_ready", j),  128'(in_ready[j]),  128'(1'b1));
         chk($sformatf("reset inst%0d out_valid", j), 128'(out_valid[j]), 128'(1'b0));
         chk($sformatf("reset inst%0d busy", j),      128'(busy[j]),      128'(1'b0));
         chk($sformatf("reset inst%0d out", j),       dout[j],            128'h0);
         n_rst[j]    = 1'b1;
         in_valid[j] = 1'b0;
      end
      @(posedge clk); #1;

      run_block(2, FIPS_IN, 1'b0, FIPS_OUT, 4, "fips fwd L4");
      run_block(2, FIPS_OUT, 1'b1, FIPS_IN, 4, "fips inv L4");
      for (int j = 0; j < 5; j++) begin
         run_block(j, FIPS_IN,  1'b0, FIPS_OUT, LAT_T[j], $sformatf("roundtrip fwd L%0d", LANES_T[j]));
         run_block(j, FIPS_OUT, 1'b1, FIPS_IN,  LAT_T[j], $sformatf("roundtrip inv L%0d", LANES_T[j]));
      end

      run_block(5, {16{8'h00}}, 1'b0, {16{8'h63}}, 4, "noshift 00");
      run_block(5, {16{8'h53}}, 1'b0, {16{8'hed}}, 4, "noshift 53");
      run_block(5, {16{8'h63}}, 1'b1, {16{8'h00}}, 4, "noshift inv 63");

      begin : backpressure
         int w;
         in_valid[2] = 1'b1; inverse[2] = 1'b0; din[2] = FIPS_IN;
         @(posedge clk); #1;
         in_valid[2] = 1'b0;
         w = 0;
         while (out_valid[2] !== 1'b1 && w < 40) begin @(posedge clk); #1; w++; end
         chk("bp latency", 128'(w), 128'd4);
         for (int i = 0; i < 10; i++) begin
            chk("bp hold data", dout[2], FIPS_OUT);
            chk("bp in_ready", 128'(in_ready[2]), 128'(1'b0));
            chk("bp out_valid", 128'(out_valid[2]), 128'(1'b1));
            in_valid[2] = 1'b1;
            inverse[2]  = ~inverse[2];
            din[2]      = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
         end
         in_valid[2]  = 1'b0;
         out_ready[2] = 1'b1;
         @(posedge clk); #1;
         out_ready[2] = 1'b0;
         chk("bp release in_ready", 128'(in_ready[2]), 128'(1'b1));
         chk("bp release out_valid", 128'(out_valid[2]), 128'(1'b0));
         chk("bp release data", dout[2], FIPS_OUT);
      end

      in_valid[0] = 1'b1; inverse[0] = 1'b0; din[0] = FIPS_IN;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      n_rst[0] = 1'b0;
      @(posedge clk); #1;
      n_rst[0] = 1'b1;
      chk("midreset in_ready", 128'(in_ready[0]), 128'(1'b1));
      chk("midreset busy", 128'(busy[0]), 128'(1'b0));
      chk("midreset out", dout[0], 128'h0);
      for (int i = 0; i < 20; i++) begin
         chk("midreset out_valid", 128'(out_valid[0]), 128'(1'b0));
         @(posedge clk); #1;
      end
      run_block(0, FIPS_IN, 1'b0, FIPS_OUT, 16, "after midreset");

      for (int t = 0; t < 3000; t++) begin
         for (int j = 0; j < NI; j++) begin
            n_rst[j]     = ($urandom_range(0, 149) != 0);
            in_valid[j]  = ($urandom_range(0, 2) == 0);
            inverse[j]   = ($urandom_range(0, 1) == 1);
            din[j]       = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_ready[j] = ($urandom_range(0, 3) != 0);
         end
         @(posedge clk); #1;
      end
      for (int j = 0; j < NI; j++) begin
         n_rst[j]     = 1'b1;
         in_valid[j]  = 1'b0;
         out_ready[j] = 1'b1;
      end
      repeat (20) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
